// File: rtl/mac_pkg.sv
// Shared constants and helpers for the parameterised convolution MAC.
// Holds the default sizing and the signed saturation-bound helper.
package mac_pkg;

  localparam int DEFAULT_WIDTH       = 14;
  localparam int DEFAULT_ACC_WIDTH   = 28;
  localparam int DEFAULT_PIPE_STAGES = 5;

  // Bounds are computed wide enough for any accumulator up to 128 bits.
  localparam int BOUND_WIDTH = 129;

  typedef logic signed [BOUND_WIDTH-1:0] bound_t;

  // Largest (upper=1) or smallest (upper=0) two's-complement value of 'width' bits.
  function automatic bound_t sat_bound(input int unsigned width, input logic upper);
    bound_t mag;
    mag = bound_t'(1) <<< (width - 1);
    if (upper) begin
      return mag - bound_t'(1);
    end
    return -mag;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Registered signed multiplier: captures the operands, then carries the
// full-precision product through PIPE_STAGES registers with valid/clear sideband.
module mult_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int PIPE_STAGES = DEFAULT_PIPE_STAGES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  input  logic                      valid_in,
  input  logic                      clear_in,
  output logic signed [2*WIDTH-1:0] product,
  output logic                      valid_out,
  output logic                      clear_out
);

  logic signed [WIDTH-1:0]   a_q;
  logic signed [WIDTH-1:0]   b_q;
  logic                      in_valid_q;
  logic                      in_clear_q;
  logic signed [2*WIDTH-1:0] full_prod;
  logic signed [2*WIDTH-1:0] prod_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]    valid_q;
  logic [PIPE_STAGES-1:0]    clear_q;

  // Operand capture; held across bubbles so the multiplier input stays quiet.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Input-stage sideband; a clear is only meaningful together with a valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_valid_q <= 1'b0;
      in_clear_q <= 1'b0;
    end else begin
      in_valid_q <= valid_in;
      in_clear_q <= valid_in & clear_in;
    end
  end

  // Operands are sign-extended first so the product keeps full precision.
  always_comb begin
    full_prod = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
  end

  // Product shift chain; data needs no reset because the valid flag qualifies it.
  always_ff @(posedge clk) begin
    prod_q[0] <= full_prod;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      prod_q[i] <= prod_q[i-1];
    end
  end

  // Valid/clear flags travel in lockstep with the product; reset flushes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      clear_q <= '0;
    end else begin
      valid_q[0] <= in_valid_q;
      clear_q[0] <= in_clear_q;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        clear_q[i] <= clear_q[i-1];
      end
    end
  end

  assign product   = prod_q[PIPE_STAGES-1];
  assign valid_out = valid_q[PIPE_STAGES-1];
  assign clear_out = clear_q[PIPE_STAGES-1];

endmodule

// File: rtl/conv_mac_param.sv
// Pipelined signed multiply-accumulate with optional saturation and a sticky
// overflow flag that restarts on every clear step.
module conv_mac_param
  import mac_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
  parameter int PIPE_STAGES = DEFAULT_PIPE_STAGES,
  parameter int SATURATE    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        valid_in,
  input  logic                        clear_in,
  output logic signed [ACC_WIDTH-1:0] f,
  output logic                        valid_out,
  output logic                        overflow
);

  localparam bound_t MAX_WIDE = sat_bound(ACC_WIDTH, 1'b1);
  localparam bound_t MIN_WIDE = sat_bound(ACC_WIDTH, 1'b0);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = MAX_WIDE[ACC_WIDTH-1:0];
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = MIN_WIDE[ACC_WIDTH-1:0];

  logic signed [2*WIDTH-1:0]   prod;
  logic                        prod_valid;
  logic                        prod_clear;
  logic signed [ACC_WIDTH:0]   prod_ext;
  logic signed [ACC_WIDTH:0]   base_ext;
  logic signed [ACC_WIDTH:0]   sum_next;
  logic                        step_ovf;
  logic signed [ACC_WIDTH-1:0] f_next;
  logic                        ovf_next;

  mult_pipe #(
    .WIDTH       (WIDTH),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .clear_in  (clear_in),
    .product   (prod),
    .valid_out (prod_valid),
    .clear_out (prod_clear)
  );

  // One extra bit of headroom: the top two bits disagree exactly when the sum leaves range.
  always_comb begin
    prod_ext = {{(ACC_WIDTH+1-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    base_ext = prod_clear ? '0 : {f[ACC_WIDTH-1], f};
    sum_next = base_ext + prod_ext;
    step_ovf = sum_next[ACC_WIDTH] ^ sum_next[ACC_WIDTH-1];
    if (step_ovf && (SATURATE != 0)) begin
      f_next = sum_next[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      f_next = sum_next[ACC_WIDTH-1:0];
    end
    ovf_next = prod_clear ? step_ovf : (overflow | step_ovf);
  end

  // Accumulator and flags update only on valid products; bubbles hold state.
  always_ff @(posedge clk) begin
    if (reset) begin
      f         <= '0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= prod_valid;
      if (prod_valid) begin
        f        <= f_next;
        overflow <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_param.sv
// Self-checking bench for conv_mac_param: directed vector table on the default
// sizing (saturating and wrapping instances side by side), hand-written reset
// sequences, and a random stream on narrow instances against a golden model.
module tb_conv_mac_param;

  localparam int W   = 14;
  localparam int AW  = 28;
  localparam int SW  = 8;
  localparam int SAW = 16;
  localparam int NROWS = 31;
  localparam int NSWEEP = 1000;
  localparam int NDRAIN = 12;

  typedef struct {
    logic v;
    logic c;
    int   a;
    int   b;
    logic ev;
    int   efs;
    logic eos;
    int   efw;
    logic eow;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic                  valid_in;
  logic                  clear_in;
  logic signed [AW-1:0]  f_sat;
  logic                  vo_sat;
  logic                  ov_sat;
  logic signed [AW-1:0]  f_wrap;
  logic                  vo_wrap;
  logic                  ov_wrap;

  logic                  reset_sw;
  logic signed [SW-1:0]  a8;
  logic signed [SW-1:0]  b8;
  logic                  v8;
  logic                  c8;
  logic signed [SAW-1:0] f_p1;
  logic                  vo_p1;
  logic                  ov_p1;
  logic signed [SAW-1:0] f_p8;
  logic                  vo_p8;
  logic                  ov_p8;

  int checks = 0;
  int errors = 0;

  conv_mac_param dut_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_sat), .valid_out(vo_sat), .overflow(ov_sat)
  );

  conv_mac_param #(.SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_wrap), .valid_out(vo_wrap), .overflow(ov_wrap)
  );

  conv_mac_param #(.WIDTH(SW), .ACC_WIDTH(SAW), .PIPE_STAGES(1)) dut_p1 (
    .clk(clk), .reset(reset_sw), .a(a8), .b(b8), .valid_in(v8), .clear_in(c8),
    .f(f_p1), .valid_out(vo_p1), .overflow(ov_p1)
  );

  conv_mac_param #(.WIDTH(SW), .ACC_WIDTH(SAW), .PIPE_STAGES(8)) dut_p8 (
    .clk(clk), .reset(reset_sw), .a(a8), .b(b8), .valid_in(v8), .clear_in(c8),
    .f(f_p8), .valid_out(vo_p8), .overflow(ov_p8)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic c, input int av, input int bv);
    valid_in = v;
    clear_in = c;
    a = av[W-1:0];
    b = bv[W-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic checkBoth(input string tag, input logic ev, input int efs, input logic eos,
                           input int efw, input logic eow);
    checkOutput($sformatf("%s vout_sat", tag), vo_sat, ev);
    checkOutput($sformatf("%s f_sat", tag), f_sat, efs);
    checkOutput($sformatf("%s ovf_sat", tag), ov_sat, eos);
    checkOutput($sformatf("%s vout_wrap", tag), vo_wrap, ev);
    checkOutput($sformatf("%s f_wrap", tag), f_wrap, efw);
    checkOutput($sformatf("%s ovf_wrap", tag), ov_wrap, eow);
  endtask

  vec_t vecs [NROWS];

  int     hist_a [NSWEEP+NDRAIN];
  int     hist_b [NSWEEP+NDRAIN];
  logic   hist_v [NSWEEP+NDRAIN];
  logic   hist_c [NSWEEP+NDRAIN];
  int     lat [2];
  longint mf [2];
  logic   mo [2];
  logic   mv [2];
  longint nxt;
  logic   step;

  initial begin
    // Row k: inputs sampled at edge k after reset release; expectations hold just after that edge.
    vecs[0]  = '{1'b1, 1'b1,     3,    -4, 1'b0,          0, 1'b0,          0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0,     0,     0, 1'b0,          0, 1'b0,          0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0,     0,     0, 1'b0,          0, 1'b0,          0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0,     0,     0, 1'b0,          0, 1'b0,          0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0,     0,     0, 1'b0,          0, 1'b0,          0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0,     0,     0, 1'b0,          0, 1'b0,          0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0,     0,     0, 1'b1,        -12, 1'b0,        -12, 1'b0};
    vecs[7]  = '{1'b0, 1'b0,     0,     0, 1'b0,        -12, 1'b0,        -12, 1'b0};
    vecs[8]  = '{1'b1, 1'b1,  8191,  8191, 1'b0,        -12, 1'b0,        -12, 1'b0};
    vecs[9]  = '{1'b1, 1'b0,  8191,  8191, 1'b0,        -12, 1'b0,        -12, 1'b0};
    vecs[10] = '{1'b1, 1'b0,  8191,  8191, 1'b0,        -12, 1'b0,        -12, 1'b0};
    vecs[11] = '{1'b1, 1'b1,     1,     1, 1'b0,        -12, 1'b0,        -12, 1'b0};
    vecs[12] = '{1'b0, 1'b0,     0,     0, 1'b0,        -12, 1'b0,        -12, 1'b0};
    vecs[13] = '{1'b0, 1'b0,     0,     0, 1'b0,        -12, 1'b0,        -12, 1'b0};
    vecs[14] = '{1'b0, 1'b0,     0,     0, 1'b1,   67092481, 1'b0,   67092481, 1'b0};
    vecs[15] = '{1'b0, 1'b0,     0,     0, 1'b1,  134184962, 1'b0,  134184962, 1'b0};
    vecs[16] = '{1'b0, 1'b0,     0,     0, 1'b1,  134217727, 1'b1,  -67158013, 1'b1};
    vecs[17] = '{1'b0, 1'b0,     0,     0, 1'b1,          1, 1'b0,          1, 1'b0};
    vecs[18] = '{1'b0, 1'b0,     0,     0, 1'b0,          1, 1'b0,          1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, -8192, -8192, 1'b0,          1, 1'b0,          1, 1'b0};
    vecs[20] = '{1'b0, 1'b0,     5,     7, 1'b0,          1, 1'b0,          1, 1'b0};
    vecs[21] = '{1'b0, 1'b1,    -3,     9, 1'b0,          1, 1'b0,          1, 1'b0};
    vecs[22] = '{1'b1, 1'b0, -8192, -8192, 1'b0,          1, 1'b0,          1, 1'b0};
    vecs[23] = '{1'b1, 1'b1, -8192,  8191, 1'b0,          1, 1'b0,          1, 1'b0};
    vecs[24] = '{1'b0, 1'b0,     0,     0, 1'b0,          1, 1'b0,          1, 1'b0};
    vecs[25] = '{1'b0, 1'b0,     0,     0, 1'b1,   67108864, 1'b0,   67108864, 1'b0};
    vecs[26] = '{1'b0, 1'b0,     0,     0, 1'b0,   67108864, 1'b0,   67108864, 1'b0};
    vecs[27] = '{1'b0, 1'b0,     0,     0, 1'b0,   67108864, 1'b0,   67108864, 1'b0};
    vecs[28] = '{1'b0, 1'b0,     0,     0, 1'b1,  134217727, 1'b1, -134217728, 1'b1};
    vecs[29] = '{1'b0, 1'b0,     0,     0, 1'b1,  -67100672, 1'b0,  -67100672, 1'b0};
    vecs[30] = '{1'b0, 1'b0,     0,     0, 1'b0,  -67100672, 1'b0,  -67100672, 1'b0};

    reset    = 1'b1;
    reset_sw = 1'b1;
    valid_in = 1'b0;
    clear_in = 1'b0;
    a = '0;
    b = '0;
    v8 = 1'b0;
    c8 = 1'b0;
    a8 = '0;
    b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkBoth("reset", 1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("reset f_p1", f_p1, 0);
    checkOutput("reset vout_p1", vo_p1, 0);
    checkOutput("reset f_p8", f_p8, 0);
    checkOutput("reset vout_p8", vo_p8, 0);

    reset    = 1'b0;
    reset_sw = 1'b0;
    $display("[TB] directed vector table");
    for (int i = 0; i < NROWS; i++) begin
      applyStimulus(vecs[i].v, vecs[i].c, vecs[i].a, vecs[i].b);
      checkBoth($sformatf("row%0d", i), vecs[i].ev, vecs[i].efs, vecs[i].eos,
                vecs[i].efw, vecs[i].eow);
    end

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 100, 100);
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    checkBoth("midreset", 1'b0, 0, 1'b0, 0, 1'b0);

    // First edge after release: accepted, sum starts from zero without clear_in.
    applyStimulus(1'b1, 1'b0, 2, 5);
    checkBoth("postreset k0", 1'b0, 0, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkBoth($sformatf("postreset k%0d", k), 1'b0, 0, 1'b0, 0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkBoth("postreset k6", 1'b1, 10, 1'b0, 10, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkBoth("postreset k7", 1'b0, 10, 1'b0, 10, 1'b0);

    $display("[TB] random sweep PIPE_STAGES=1 and 8");
    lat[0] = 2;
    lat[1] = 9;
    for (int d = 0; d < 2; d++) begin
      mf[d] = 0;
      mo[d] = 1'b0;
    end
    for (int t = 0; t < NSWEEP + NDRAIN; t++) begin
      if (t < NSWEEP) begin
        hist_v[t] = ($urandom_range(3, 0) != 0);
        hist_c[t] = ($urandom_range(7, 0) == 0);
        hist_a[t] = int'($urandom_range(255, 0)) - 128;
        hist_b[t] = int'($urandom_range(255, 0)) - 128;
      end else begin
        hist_v[t] = 1'b0;
        hist_c[t] = 1'b0;
        hist_a[t] = 0;
        hist_b[t] = 0;
      end
      v8 = hist_v[t];
      c8 = hist_c[t];
      a8 = SW'(hist_a[t]);
      b8 = SW'(hist_b[t]);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        mv[d] = 1'b0;
        if (t - lat[d] >= 0) begin
          if (hist_v[t - lat[d]]) begin
            mv[d] = 1'b1;
            nxt = (hist_c[t - lat[d]] ? 64'sd0 : mf[d]) +
                  longint'(hist_a[t - lat[d]]) * longint'(hist_b[t - lat[d]]);
            step = (nxt > 32767) || (nxt < -32768);
            if (nxt > 32767) begin
              mf[d] = 32767;
            end else if (nxt < -32768) begin
              mf[d] = -32768;
            end else begin
              mf[d] = nxt;
            end
            mo[d] = hist_c[t - lat[d]] ? step : (mo[d] | step);
          end
        end
      end
      checkOutput($sformatf("sweep p1 t%0d vout", t), vo_p1, mv[0]);
      checkOutput($sformatf("sweep p1 t%0d f", t), f_p1, mf[0]);
      checkOutput($sformatf("sweep p1 t%0d ovf", t), ov_p1, mo[0]);
      checkOutput($sformatf("sweep p8 t%0d vout", t), vo_p8, mv[1]);
      checkOutput($sformatf("sweep p8 t%0d f", t), f_p8, mf[1]);
      checkOutput($sformatf("sweep p8 t%0d ovf", t), ov_p8, mo[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
